// File: rtl/feeder_pkg.sv
// Shared types and helpers for the serial feeder: FSM state encoding and counter sizing.
package feeder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit-counter width for a given word width (at least one bit).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_feeder.sv
// Parallel-to-serial feeder with a one-word hold buffer so consecutive words
// leave on A with no idle bit between them; drives IDLE_BIT when empty.
module serial_feeder
  import feeder_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             A,
  output logic             shifting,
  output logic             word_done
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d;

  logic             out_bit;
  logic [WIDTH-1:0] sreg_shifted;
  logic             accept;

  // Out end of the shift register and the one-step shift toward it.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign out_bit      = sreg_q[WIDTH-1];
      assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign out_bit      = sreg_q[0];
      assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign din_ready = !hold_full_q;
  assign accept    = din_valid && din_ready;
  assign shifting  = (state_q == SHIFT);
  assign word_done = (state_q == SHIFT) && (cnt_q == '0);
  assign A         = (state_q == SHIFT) ? out_bit : IDLE_BIT;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = din;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          sreg_d = sreg_shifted;
          cnt_d  = cnt_q - 1'b1;
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Last bit now on A: reload from hold so the next word follows without a gap.
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = CNT_LAST;
        end else if (accept) begin
          sreg_d = din;
          cnt_d  = CNT_LAST;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: tb/tb_serial_feeder.sv
// Scoreboard bench for serial_feeder: MSB-first and LSB-first instances on one clock.
module tb_serial_feeder;

  typedef struct packed {
    logic a;
    logic done;
  } exp_bit_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din_m, din_l;
  logic       vld_m, vld_l;
  logic       rdy_m, rdy_l;
  logic       a_m, a_l;
  logic       sh_m, sh_l;
  logic       done_m, done_l;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  exp_bit_t exp_m[$];
  exp_bit_t exp_l[$];

  always #5 clk = ~clk;

  serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
    .clk(clk), .reset(reset), .din(din_m), .din_valid(vld_m), .din_ready(rdy_m),
    .A(a_m), .shifting(sh_m), .word_done(done_m)
  );

  serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .reset(reset), .din(din_l), .din_valid(vld_l), .din_ready(rdy_l),
    .A(a_l), .shifting(sh_l), .word_done(done_l)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitors: pop one expected bit per shifting cycle; idle cycles must show IDLE_BIT
  // and an empty scoreboard (a pending word while idle means a gap appeared).
  always @(negedge clk) begin
    if (mon_en) begin
      if (sh_m) begin
        if (exp_m.size() == 0) begin
          chk("m_unexpected_bit", 32'(sh_m), 32'd0);
        end else begin
          exp_bit_t e;
          e = exp_m.pop_front();
          chk("m_A", 32'(a_m), 32'(e.a));
          chk("m_word_done", 32'(done_m), 32'(e.done));
          $display("m bit: A=%0b done=%0b (exp %0b/%0b)", a_m, done_m, e.a, e.done);
        end
      end else begin
        chk("m_idle_A", 32'(a_m), 32'd1);
        chk("m_idle_done", 32'(done_m), 32'd0);
        chk("m_gap_pending", 32'(exp_m.size()), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (sh_l) begin
        if (exp_l.size() == 0) begin
          chk("l_unexpected_bit", 32'(sh_l), 32'd0);
        end else begin
          exp_bit_t e;
          e = exp_l.pop_front();
          chk("l_A", 32'(a_l), 32'(e.a));
          chk("l_word_done", 32'(done_l), 32'(e.done));
          $display("l bit: A=%0b done=%0b (exp %0b/%0b)", a_l, done_l, e.a, e.done);
        end
      end else begin
        chk("l_idle_A", 32'(a_l), 32'd1);
        chk("l_idle_done", 32'(done_l), 32'd0);
        chk("l_gap_pending", 32'(exp_l.size()), 32'd0);
      end
    end
  end

  // Called at posedge+1. Holds valid until an edge with ready high, then pushes the
  // expected serial bits. Returns the number of cycles spent waiting on ready.
  task automatic put_m(input logic [7:0] w, output int waits);
    bit ok;
    ok    = 1'b0;
    waits = 0;
    din_m = w;
    vld_m = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = rdy_m;
      if (!ok) waits++;
      @(posedge clk);
      #1;
    end
    vld_m = 1'b0;
    if (!ok) begin
      chk("m_accept_timeout", 32'd0, 32'd1);
    end else begin
      $display("m accept %02h after %0d wait cycles", w, waits);
      for (int i = 7; i >= 0; i--) exp_m.push_back('{a: w[i], done: (i == 0)});
    end
  endtask

  task automatic put_l(input logic [7:0] w, output int waits);
    bit ok;
    ok    = 1'b0;
    waits = 0;
    din_l = w;
    vld_l = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = rdy_l;
      if (!ok) waits++;
      @(posedge clk);
      #1;
    end
    vld_l = 1'b0;
    if (!ok) begin
      chk("l_accept_timeout", 32'd0, 32'd1);
    end else begin
      $display("l accept %02h after %0d wait cycles", w, waits);
      for (int i = 0; i < 8; i++) exp_l.push_back('{a: w[i], done: (i == 7)});
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w;
    reset = 1'b1;
    din_m = 8'h00;
    din_l = 8'h00;
    vld_m = 1'b0;
    vld_l = 1'b0;

    // Reset held for 2 cycles, then 5 idle cycles.
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("idle_ready_m", 32'(rdy_m), 32'd1);
      chk("idle_ready_l", 32'(rdy_l), 32'd1);
      chk("idle_shifting_m", 32'(sh_m), 32'd0);
      tick(1);
    end

    // Single MSB-first word: A = 1,0,1,1,0,0,1,0.
    put_m(8'b1011_0010, w);
    chk("single_wait", 32'(w), 32'd0);
    tick(12);

    // LSB-first: 8'b0000_0110 -> A = 0,1,1,0,0,0,0,0.
    put_l(8'b0000_0110, w);
    tick(12);

    // Back-to-back with valid held: A5 starts in IDLE, 3C goes to hold the next
    // cycle, FF waits 7 cycles until A5's last bit moves 3C out of hold.
    put_m(8'hA5, w);
    chk("b2b_wait_A5", 32'(w), 32'd0);
    put_m(8'h3C, w);
    chk("b2b_wait_3C", 32'(w), 32'd0);
    chk("b2b_ready_low", 32'(rdy_m), 32'd0);
    put_m(8'hFF, w);
    chk("b2b_wait_FF", 32'(w), 32'd7);
    chk("b2b_ready_low_again", 32'(rdy_m), 32'd0);
    tick(20);

    // Back-to-back LSB-first pair.
    put_l(8'h81, w);
    put_l(8'h5A, w);
    chk("l_b2b_wait", 32'(w), 32'd0);
    tick(20);

    // Reset while the 4th bit of F0 is on A, with 0F in hold.
    put_m(8'hF0, w);
    put_m(8'h0F, w);
    tick(2);
    reset = 1'b1;
    tick(1);
    exp_m.delete();
    chk("rst_A", 32'(a_m), 32'd1);
    chk("rst_shifting", 32'(sh_m), 32'd0);
    chk("rst_ready", 32'(rdy_m), 32'd1);
    chk("rst_done", 32'(done_m), 32'd0);
    reset = 1'b0;
    tick(20);

    chk("end_queue_m", 32'(exp_m.size()), 32'd0);
    chk("end_queue_l", 32'(exp_l.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
